// File: rtl/uart_rx_16x.sv
// uart_rx_16x: 16x oversampling 8N1 serial receiver with a byte holding register.
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   rxd        in   asynchronous serial line, idle high
//   rd         in   one-cycle read strobe, consumes the held byte
//   rx_data    out  [7:0] last received byte
//   rx_valid   out  holding register has an unread byte
//   rx_ferr    out  held byte had its stop bit sampled low
//   rx_overrun out  a byte was overwritten before being read
module uart_rx_16x #(
  parameter int unsigned CLKSPEED = 40000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DIVISOR  = (CLKSPEED + 8 * BAUD) / (16 * BAUD)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       rx_overrun
);

  localparam int unsigned DIV_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned SC_W   = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic              sync1, rxs;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [SC_W-1:0]   sc;
  logic              s7, s8;
  logic              maj;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shift;

  logic start_det;
  logic shift_en;
  logic idx_clr;
  logic idx_inc;
  logic load;
  logic at_s9;
  logic at_s15;

  // Two-flop synchroniser, reset to the idle line level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  // 16x tick generator; restarted on the start edge so ticks align to it
  assign tick = (div_cnt == DIV_W'(DIVISOR - 1));

  always_ff @(posedge clk) begin
    if (reset || start_det || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Sample counter within a bit, wraps 15 -> 0
  always_ff @(posedge clk) begin
    if (reset || start_det) begin
      sc <= '0;
    end else if (tick && (state != IDLE)) begin
      sc <= sc + SC_W'(1);
    end
  end

  assign at_s9  = tick && (sc == SC_W'(9));
  assign at_s15 = tick && (sc == SC_W'(15));

  // Capture samples 7 and 8; sample 9 is the live rxs at the deciding tick
  always_ff @(posedge clk) begin
    if (reset) begin
      s7 <= 1'b1;
      s8 <= 1'b1;
    end else if (tick && (sc == SC_W'(7))) begin
      s7 <= rxs;
    end else if (tick && (sc == SC_W'(8))) begin
      s8 <= rxs;
    end
  end

  assign maj = (s7 & s8) | (s7 & rxs) | (s8 & rxs);

  // Frame sequencing: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame sequencing: next state and datapath strobes
  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    shift_en  = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_nxt = START;
          start_det = 1'b1;
        end
      end
      START: begin
        if (at_s9 && maj) begin
          state_nxt = IDLE;
        end else if (at_s15) begin
          state_nxt = DATA;
          idx_clr   = 1'b1;
        end
      end
      DATA: begin
        if (at_s9) begin
          shift_en = 1'b1;
        end
        if (at_s15) begin
          if (idx == IDX_W'(DATA_W - 1)) begin
            state_nxt = STOP;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      STOP: begin
        // Return to IDLE mid stop bit so the next start edge is not missed
        if (at_s9) begin
          load      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit index and LSB-first shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      shift <= '0;
    end else begin
      if (idx_clr) begin
        idx <= '0;
      end else if (idx_inc) begin
        idx <= idx + IDX_W'(1);
      end
      if (shift_en) begin
        shift <= {maj, shift[DATA_W-1:1]};
      end
    end
  end

  // Holding register and status flags; a load takes priority over a read
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (load) begin
      rx_data    <= shift;
      rx_valid   <= 1'b1;
      rx_ferr    <= ~maj;
      // Overrun only if the old byte is still unread and not being read now
      rx_overrun <= rx_valid & ~rd;
    end else if (rd && rx_valid) begin
      rx_valid   <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_16x.sv
// tb_uart_rx_16x: directed self-checking bench for uart_rx_16x at 16 clocks per bit.
module tb_uart_rx_16x;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic       rx_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc       = 0;
  int start_cyc = 0;
  int load_cyc  = -1;
  logic prev_v  = 1'b0;

  uart_rx_16x #(
    .CLKSPEED(1600000),
    .BAUD    (100000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rd        (rd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ferr   (rx_ferr),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record the cycle on which rx_valid rises
  always @(negedge clk) begin
    if (rx_valid && !prev_v) load_cyc = cyc;
    prev_v = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Send one 8N1 frame; per_x100 is the bit period in hundredths of a clock.
  // With spike set, each data bit is inverted for the single cycle that
  // sample 7 sees.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                           input int per_x100, input logic spike);
    logic [9:0] bits;
    int t;
    bits = {stop_bit, b, 1'b0};
    t = 0;
    for (int i = 0; i < 10; i++) begin
      int endc;
      int bstart;
      endc   = ((i + 1) * per_x100 + 50) / 100;
      bstart = t;
      while (t < endc) begin
        rxd = bits[i];
        if (spike && i >= 1 && i <= 8 && (t - bstart) == 8) rxd = ~bits[i];
        @(negedge clk);
        t++;
      end
    end
    rxd = 1'b1;
  endtask

  task automatic do_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    reset = 1'b1;
    rxd   = 1'b1;
    rd    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle line after reset
    idle(200);
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_ferr", 32'(rx_ferr), 32'h0);
    check("rst_ovr", 32'(rx_overrun), 32'h0);

    // 0xA5 with latency from start edge
    start_cyc = cyc;
    send_byte(8'hA5, 1'b1, 1600, 1'b0);
    idle(20);
    lat = load_cyc - start_cyc;
    check("a5_valid", 32'(rx_valid), 32'h1);
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_ferr", 32'(rx_ferr), 32'h0);
    if (!(lat >= 154 && lat <= 158)) $display("latency measured %0d clocks", lat);
    check("a5_latency_ok", 32'(lat >= 154 && lat <= 158), 32'h1);
    do_rd();
    check("a5_rd_valid", 32'(rx_valid), 32'h0);

    // Short glitch is a false start
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    idle(200);
    check("glitch_valid", 32'(rx_valid), 32'h0);

    // Single-cycle spikes on sample 7 are outvoted
    send_byte(8'h3C, 1'b1, 1600, 1'b1);
    idle(20);
    check("spike_valid", 32'(rx_valid), 32'h1);
    check("spike_data", 32'(rx_data), 32'h3C);
    check("spike_ferr", 32'(rx_ferr), 32'h0);
    do_rd();

    // Framing error
    send_byte(8'h55, 1'b0, 1600, 1'b0);
    idle(40);
    check("ferr_data", 32'(rx_data), 32'h55);
    check("ferr_valid", 32'(rx_valid), 32'h1);
    check("ferr_flag", 32'(rx_ferr), 32'h1);
    do_rd();
    check("ferr_rd_valid", 32'(rx_valid), 32'h0);
    check("ferr_rd_flag", 32'(rx_ferr), 32'h0);

    // Back-to-back without a read: overrun
    send_byte(8'h11, 1'b1, 1600, 1'b0);
    send_byte(8'h22, 1'b1, 1600, 1'b0);
    idle(20);
    check("ovr_data", 32'(rx_data), 32'h22);
    check("ovr_valid", 32'(rx_valid), 32'h1);
    check("ovr_flag", 32'(rx_overrun), 32'h1);
    do_rd();
    check("ovr_rd_flag", 32'(rx_overrun), 32'h0);
    check("ovr_rd_valid", 32'(rx_valid), 32'h0);

    // Read coincident with the second load: load wins, no overrun
    send_byte(8'h11, 1'b1, 1600, 1'b0);
    fork
      send_byte(8'h22, 1'b1, 1600, 1'b0);
      begin
        repeat (156) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    idle(20);
    check("coinc_valid", 32'(rx_valid), 32'h1);
    check("coinc_data", 32'(rx_data), 32'h22);
    check("coinc_ovr", 32'(rx_overrun), 32'h0);

    // Reset during bit 4 of 0xFF aborts the frame
    fork
      send_byte(8'hFF, 1'b1, 1600, 1'b0);
      begin
        repeat (16 * 5 + 8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(rx_valid), 32'h0);
        check("midrst_data", 32'(rx_data), 32'h00);
        reset = 1'b0;
      end
    join
    idle(40);
    check("midrst_nobyte", 32'(rx_valid), 32'h0);
    send_byte(8'h81, 1'b1, 1600, 1'b0);
    idle(20);
    check("r81_valid", 32'(rx_valid), 32'h1);
    check("r81_data", 32'(rx_data), 32'h81);
    do_rd();

    // Baud +3% (shorter bit) and -3% (longer bit)
    send_byte(8'h81, 1'b1, 1553, 1'b0);
    idle(20);
    check("fast_valid", 32'(rx_valid), 32'h1);
    check("fast_data", 32'(rx_data), 32'h81);
    check("fast_ferr", 32'(rx_ferr), 32'h0);
    do_rd();
    send_byte(8'h81, 1'b1, 1650, 1'b0);
    idle(20);
    check("slow_valid", 32'(rx_valid), 32'h1);
    check("slow_data", 32'(rx_data), 32'h81);
    check("slow_ferr", 32'(rx_ferr), 32'h0);
    check("slow_ovr", 32'(rx_overrun), 32'h0);
    do_rd();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
